multicycle_controller: RTL and testbench
========================================

# multicycle_controller

Moore-style control FSM that sequences the multicycle MIPS datapath: it drives the `program_counter` enable and next-PC source select, instruction-register capture, memory strobes, register-file write and ALU operand/operation selects. One instruction executes over 3–5+ states. Memory accesses wait on a `mem_ready` handshake, so the PC advances only once the instruction fetch completes.

## Interface
- No parameters.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous reset, active-high.
- `opcode`  in  6  instruction bits [31:26], taken from the instruction register.
- `zero`  in  1  ALU zero flag, used in BRANCH.
- `mem_ready`  in  1  memory completes the current read/write this cycle.
- `pc_en`  out  1  load enable for the PC register.
- `pc_src`  out  2  next-PC select: 00 ALU result, 01 ALU-out register (branch target), 10 jump target.
- `iord`  out  1  memory address select: 0 PC, 1 ALU-out.
- `mem_read`, `mem_write`  out  1 each  memory strobes.
- `ir_write`  out  1  instruction-register capture.
- `reg_write`  out  1  register-file write.
- `reg_dst`  out  1  write register select: 0 rt, 1 rd.
- `mem_to_reg`  out  1  write-data select: 0 ALU-out, 1 memory data.
- `alu_src_a`  out  1  ALU A select: 0 PC, 1 register A.
- `alu_src_b`  out  2  ALU B select: 00 register B, 01 constant 4, 10 sign-extended immediate, 11 immediate shifted left by 2.
- `alu_op`  out  2  ALU operation: 00 add, 01 subtract, 10 decode from funct.
- `illegal_op`  out  1  unsupported opcode detected in DECODE.
- `state`  out  4  current state encoding, for debug and verification.

## Operation
- State encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXECUTE 6, ALUWB 7, BRANCH 8, JUMP 9, ADDIEX 10, ADDIWB 11. Codes 12–15 are unreachable; if entered, the next state is FETCH.
- Outputs not listed for a state are 0.
- FETCH
  - Outputs: `mem_read`=1, `iord`=0, `alu_src_a`=0, `alu_src_b`=01, `alu_op`=00, `pc_src`=00.
  - `ir_write`=`pc_en`=`mem_ready`.
  - Stays in FETCH while `mem_ready`=0; goes to DECODE when `mem_ready`=1.
- DECODE
  - Outputs: `alu_src_a`=0, `alu_src_b`=11, `alu_op`=00.
  - Next state by opcode: 0x23 or 0x2B → MEMADR; 0x00 → EXECUTE; 0x04 → BRANCH; 0x02 → JUMP; 0x08 → ADDIEX.
  - Any other opcode: `illegal_op`=1 and next state FETCH; the instruction is dropped.
- MEMADR
  - Outputs: `alu_src_a`=1, `alu_src_b`=10, `alu_op`=00.
  - Next state: MEMRD if opcode is 0x23, else MEMWR.
- MEMRD: `mem_read`=1, `iord`=1. Waits for `mem_ready`, then goes to MEMWB.
- MEMWB: `reg_write`=1, `reg_dst`=0, `mem_to_reg`=1. Next state FETCH.
- MEMWR: `mem_write`=1, `iord`=1. Waits for `mem_ready`, then goes to FETCH.
- EXECUTE: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=10. Next state ALUWB.
- ALUWB: `reg_write`=1, `reg_dst`=1, `mem_to_reg`=0. Next state FETCH.
- BRANCH
  - Outputs: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=01, `pc_src`=01.
  - `pc_en`=`zero`, combinational within the cycle.
  - Next state FETCH.
- JUMP: `pc_src`=10, `pc_en`=1. Next state FETCH.
- ADDIEX: `alu_src_a`=1, `alu_src_b`=10, `alu_op`=00. Next state ADDIWB.
- ADDIWB: `reg_write`=1, `reg_dst`=0, `mem_to_reg`=0. Next state FETCH.
- `opcode` is sampled only in DECODE and MEMADR; it is held stable by the IR outside FETCH.

## Timing
- Only the state register is sequential. All outputs decode combinationally from the state and the current-cycle `zero`/`mem_ready`.
- Reset:
  - A rising edge with `rst`=1 loads FETCH, regardless of the current state or a pending handshake.
  - While `rst`=1, every output is forced to 0, including `state`=0. No write strobe, `pc_en` or `ir_write` may assert during reset.
- Minimum cycles per instruction (with `mem_ready`=1 throughout): lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.
- Each cycle of `mem_ready`=0 in FETCH, MEMRD or MEMWR adds one cycle.
  - The memory strobe and address select stay constant while waiting.
  - `pc_en` and `ir_write` remain 0 until the ready cycle.
- Exactly one `pc_en` pulse occurs per fetch. A branch or jump adds at most one further pulse.
- `illegal_op` is a single-cycle pulse, asserted only in DECODE.

## Test plan
- Reset mid-operation: hold `rst`=1 for 2 edges while in MEMWR with `mem_write`=1 → all outputs 0 during reset; `state`=0 after the first reset edge; after release, the first FETCH cycle has `mem_read`=1.
- lw (opcode 0x23), `mem_ready`=1 always → state sequence 0,1,2,3,4,0. `pc_en` is 1 only in cycle 0. `reg_write`=1 with `mem_to_reg`=1 in state 4.
- Fetch stall: `mem_ready`=0 for 3 cycles, then 1 → FETCH lasts 4 cycles; `pc_en`/`ir_write` assert only in the 4th; `mem_read`=1 throughout.
- beq (0x04): with `zero`=1 → in BRANCH, `pc_en`=1 and `pc_src`=01. With `zero`=0 → `pc_en`=0. Both cases reach FETCH after 3 cycles.
- j (0x02) then R-type (0x00) back-to-back → states 0,1,9,0,1,6,7,0. In state 7, `reg_dst`=1 and `reg_write`=1.
- Illegal opcode 0x3F → `illegal_op`=1 for one cycle in DECODE; next state 0; no `reg_write` or `mem_write` is asserted.

Source files
------------

// File: rtl/multicycle_controller.sv
// ----------------------------------------------------------------------------
// multicycle_controller
//
// Purpose:
//   Moore-style control FSM for a multicycle MIPS datapath. It steps one
//   instruction through FETCH, DECODE and a short opcode-specific tail of
//   states. The decoded control lines drive the PC enable and next-PC source,
//   instruction-register capture, memory strobes, register-file write and the
//   ALU operand/operation selects. Memory accesses in FETCH, MEMRD and MEMWR
//   hold until mem_ready, so the PC only advances when a fetch completes.
//
// Ports:
//   clk         in   1  rising-edge clock
//   rst         in   1  synchronous active-high reset
//   opcode      in   6  instruction bits [31:26] from the instruction register
//   zero        in   1  ALU zero flag, used by BRANCH
//   mem_ready   in   1  memory completes the current access this cycle
//   pc_en       out  1  PC load enable
//   pc_src      out  2  next-PC select (00 ALU, 01 ALU-out, 10 jump target)
//   iord        out  1  memory address select (0 PC, 1 ALU-out)
//   mem_read    out  1  memory read strobe
//   mem_write   out  1  memory write strobe
//   ir_write    out  1  instruction-register capture
//   reg_write   out  1  register-file write
//   reg_dst     out  1  write register select (0 rt, 1 rd)
//   mem_to_reg  out  1  write-data select (0 ALU-out, 1 memory data)
//   alu_src_a   out  1  ALU A select (0 PC, 1 register A)
//   alu_src_b   out  2  ALU B select (00 B, 01 four, 10 imm, 11 imm<<2)
//   alu_op      out  2  ALU operation (00 add, 01 sub, 10 funct decode)
//   illegal_op  out  1  unsupported opcode seen in DECODE
//   state       out  4  current state encoding, for debug
// ----------------------------------------------------------------------------
module multicycle_controller (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_en,
  output logic [1:0] pc_src,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       illegal_op,
  output logic [3:0] state
);

  // Supported opcodes.
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // Operand / operation select encodings.
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_IMM4 = 2'b11;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // State encodings are visible on the debug port, so they are fixed.
  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXECUTE = 4'd6,
    ALUWB   = 4'd7,
    BRANCH  = 4'd8,
    JUMP    = 4'd9,
    ADDIEX  = 4'd10,
    ADDIWB  = 4'd11
  } state_e;

  state_e state_q;
  state_e state_d;

  // The state register is the only storage in the controller. Reset wins
  // over any pending handshake and always returns to FETCH.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. The opcode is only looked at in DECODE and MEMADR,
  // where the instruction register is guaranteed stable. Unsupported
  // opcodes fall back to FETCH, dropping the instruction, and any of the
  // unused codes 12-15 also recover to FETCH.
  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH: begin
        if (mem_ready) begin
          state_d = DECODE;
        end else begin
          state_d = FETCH;
        end
      end
      DECODE: begin
        case (opcode)
          OP_LW,
          OP_SW:    state_d = MEMADR;
          OP_RTYPE: state_d = EXECUTE;
          OP_BEQ:   state_d = BRANCH;
          OP_J:     state_d = JUMP;
          OP_ADDI:  state_d = ADDIEX;
          default:  state_d = FETCH;
        endcase
      end
      MEMADR: begin
        if (opcode == OP_LW) begin
          state_d = MEMRD;
        end else begin
          state_d = MEMWR;
        end
      end
      MEMRD: begin
        if (mem_ready) begin
          state_d = MEMWB;
        end else begin
          state_d = MEMRD;
        end
      end
      MEMWB:   state_d = FETCH;
      MEMWR: begin
        if (mem_ready) begin
          state_d = FETCH;
        end else begin
          state_d = MEMWR;
        end
      end
      EXECUTE: state_d = ALUWB;
      ALUWB:   state_d = FETCH;
      BRANCH:  state_d = FETCH;
      JUMP:    state_d = FETCH;
      ADDIEX:  state_d = ADDIWB;
      ADDIWB:  state_d = FETCH;
      default: state_d = FETCH;
    endcase
  end

  // Output decode. Everything defaults to 0 and each state raises only
  // what it needs. While rst is high the whole block is held at 0 so no
  // strobe, PC load or IR capture can slip out during reset, even though
  // state_q itself only changes on the next edge. The PC/IR loads in FETCH
  // and the branch PC load follow mem_ready/zero in the same cycle, which
  // keeps a stalled fetch from advancing the PC.
  always_comb begin
    pc_en      = 1'b0;
    pc_src     = PCSRC_ALU;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_REG;
    alu_op     = ALUOP_ADD;
    illegal_op = 1'b0;
    if (!rst) begin
      case (state_q)
        FETCH: begin
          mem_read  = 1'b1;
          iord      = 1'b0;
          alu_src_a = 1'b0;
          alu_src_b = SRCB_FOUR;
          alu_op    = ALUOP_ADD;
          pc_src    = PCSRC_ALU;
          ir_write  = mem_ready;
          pc_en     = mem_ready;
        end
        DECODE: begin
          alu_src_a = 1'b0;
          alu_src_b = SRCB_IMM4;
          alu_op    = ALUOP_ADD;
          case (opcode)
            OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_J, OP_ADDI: illegal_op = 1'b0;
            default:                                       illegal_op = 1'b1;
          endcase
        end
        MEMADR: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
          alu_op    = ALUOP_ADD;
        end
        MEMRD: begin
          mem_read = 1'b1;
          iord     = 1'b1;
        end
        MEMWB: begin
          reg_write  = 1'b1;
          reg_dst    = 1'b0;
          mem_to_reg = 1'b1;
        end
        MEMWR: begin
          mem_write = 1'b1;
          iord      = 1'b1;
        end
        EXECUTE: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_REG;
          alu_op    = ALUOP_FUNCT;
        end
        ALUWB: begin
          reg_write  = 1'b1;
          reg_dst    = 1'b1;
          mem_to_reg = 1'b0;
        end
        BRANCH: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_REG;
          alu_op    = ALUOP_SUB;
          pc_src    = PCSRC_ALUOUT;
          pc_en     = zero;
        end
        JUMP: begin
          pc_src = PCSRC_JUMP;
          pc_en  = 1'b1;
        end
        ADDIEX: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
          alu_op    = ALUOP_ADD;
        end
        ADDIWB: begin
          reg_write  = 1'b1;
          reg_dst    = 1'b0;
          mem_to_reg = 1'b0;
        end
        default: begin
          pc_en = 1'b0;
        end
      endcase
    end
  end

  // Debug view of the state, masked to 0 during reset like every output.
  always_comb begin
    state = rst ? 4'd0 : state_q;
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// ----------------------------------------------------------------------------
// tb_multicycle_controller
//
// Purpose:
//   Directed self-checking bench for multicycle_controller. Each step drives
//   one cycle of inputs and queues the expected state and control vector;
//   the entry is popped and compared at the falling edge of that cycle.
// ----------------------------------------------------------------------------
module tb_multicycle_controller;

  logic       clk;
  logic       rst;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       pc_en;
  logic [1:0] pc_src;
  logic       iord;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       reg_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic       illegal_op;
  logic [3:0] state;

  int passCount  = 0;
  int checkCount = 0;

  typedef struct packed {
    logic [3:0]  st;
    logic [15:0] ctl;
  } expT;

  expT scoreboard[$];

  multicycle_controller dut (
    .clk        (clk),
    .rst        (rst),
    .opcode     (opcode),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .pc_en      (pc_en),
    .pc_src     (pc_src),
    .iord       (iord),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .ir_write   (ir_write),
    .reg_write  (reg_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .illegal_op (illegal_op),
    .state      (state)
  );

  // Free-running 10-unit clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Control vector the specification's state table calls for, packed as
  // {pc_en, pc_src, iord, mem_read, mem_write, ir_write, reg_write,
  //  reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, illegal_op}.
  function automatic logic [15:0] expCtl(input logic [3:0] st, input logic [5:0] op,
                                         input logic z, input logic rdy, input logic r);
    logic       pcEn, iordE, mr, mw, irw, rw, rd, m2r, asa, ill;
    logic [1:0] ps, asb, aop;
    pcEn = 0; iordE = 0; mr = 0; mw = 0; irw = 0; rw = 0; rd = 0;
    m2r = 0; asa = 0; ill = 0; ps = 2'b00; asb = 2'b00; aop = 2'b00;
    if (!r) begin
      case (st)
        4'd0:  begin mr = 1; asb = 2'b01; pcEn = rdy; irw = rdy; end
        4'd1:  begin asb = 2'b11;
                 ill = !(op == 6'h23 || op == 6'h2B || op == 6'h00 ||
                         op == 6'h04 || op == 6'h02 || op == 6'h08); end
        4'd2:  begin asa = 1; asb = 2'b10; end
        4'd3:  begin mr = 1; iordE = 1; end
        4'd4:  begin rw = 1; m2r = 1; end
        4'd5:  begin mw = 1; iordE = 1; end
        4'd6:  begin asa = 1; aop = 2'b10; end
        4'd7:  begin rw = 1; rd = 1; end
        4'd8:  begin asa = 1; aop = 2'b01; ps = 2'b01; pcEn = z; end
        4'd9:  begin ps = 2'b10; pcEn = 1; end
        4'd10: begin asa = 1; asb = 2'b10; end
        4'd11: begin rw = 1; end
        default: begin pcEn = 0; end
      endcase
    end
    return {pcEn, ps, iordE, mr, mw, irw, rw, rd, m2r, asa, asb, aop, ill};
  endfunction

  // Pop the oldest expectation and compare it with what the DUT shows now.
  task automatic checkOutput(input string tag);
    expT         e;
    logic [15:0] obs;
    obs = {pc_en, pc_src, iord, mem_read, mem_write, ir_write, reg_write,
           reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, illegal_op};
    checkCount++;
    assert (scoreboard.size() > 0) passCount++;
    else $error("[TB] FAIL %s queue: observed empty required entry", tag);
    if (scoreboard.size() > 0) begin
      e = scoreboard.pop_front();
      checkCount++;
      assert (state === e.st) passCount++;
      else $error("[TB] FAIL %s state: observed %0d required %0d", tag, state, e.st);
      checkCount++;
      assert (obs === e.ctl) passCount++;
      else $error("[TB] FAIL %s ctl: observed %b required %b", tag, obs, e.ctl);
    end
  endtask

  // Drive one cycle of inputs, queue the expectation, check mid-cycle,
  // then move just past the next rising edge.
  task automatic applyStimulus(input logic [5:0] op, input logic z, input logic rdy,
                               input logic r, input logic [3:0] expSt, input string tag);
    opcode    = op;
    zero      = z;
    mem_ready = rdy;
    rst       = r;
    scoreboard.push_back('{st: expSt, ctl: expCtl(expSt, op, z, rdy, r)});
    @(negedge clk);
    checkOutput(tag);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; opcode = 6'h00; zero = 1'b0; mem_ready = 1'b0;

    // Power-on reset, with handshake inputs high to prove they are masked.
    applyStimulus(6'h00, 1, 1, 1, 4'd0, "reset0");
    applyStimulus(6'h00, 1, 1, 1, 4'd0, "reset1");

    // lw with memory always ready: 0,1,2,3,4.
    applyStimulus(6'h23, 1, 1, 0, 4'd0, "lw_fetch");
    applyStimulus(6'h23, 1, 1, 0, 4'd1, "lw_decode");
    applyStimulus(6'h23, 1, 1, 0, 4'd2, "lw_memadr");
    applyStimulus(6'h23, 1, 1, 0, 4'd3, "lw_memrd");
    applyStimulus(6'h23, 1, 1, 0, 4'd4, "lw_memwb");

    // Fetch stalled for three cycles, then beq taken.
    for (int i = 0; i < 3; i++) applyStimulus(6'h04, 1, 0, 0, 4'd0, "stall_fetch");
    applyStimulus(6'h04, 1, 1, 0, 4'd0, "stall_ready");
    applyStimulus(6'h04, 1, 1, 0, 4'd1, "beq1_decode");
    applyStimulus(6'h04, 1, 1, 0, 4'd8, "beq1_branch_taken");

    // beq not taken.
    applyStimulus(6'h04, 0, 1, 0, 4'd0, "beq0_fetch");
    applyStimulus(6'h04, 0, 1, 0, 4'd1, "beq0_decode");
    applyStimulus(6'h04, 0, 1, 0, 4'd8, "beq0_branch_nottaken");

    // j followed by R-type: 0,1,9,0,1,6,7.
    applyStimulus(6'h02, 1, 1, 0, 4'd0, "j_fetch");
    applyStimulus(6'h02, 1, 1, 0, 4'd1, "j_decode");
    applyStimulus(6'h02, 1, 1, 0, 4'd9, "j_jump");
    applyStimulus(6'h00, 1, 1, 0, 4'd0, "r_fetch");
    applyStimulus(6'h00, 1, 1, 0, 4'd1, "r_decode");
    applyStimulus(6'h00, 1, 1, 0, 4'd6, "r_execute");
    applyStimulus(6'h00, 1, 1, 0, 4'd7, "r_aluwb");

    // Illegal opcode: one-cycle pulse in DECODE, then straight to FETCH.
    applyStimulus(6'h3F, 1, 1, 0, 4'd0, "ill_fetch");
    applyStimulus(6'h3F, 1, 1, 0, 4'd1, "ill_decode");

    // addi: 0,1,10,11.
    applyStimulus(6'h08, 1, 1, 0, 4'd0, "addi_fetch");
    applyStimulus(6'h08, 1, 1, 0, 4'd1, "addi_decode");
    applyStimulus(6'h08, 1, 1, 0, 4'd10, "addi_ex");
    applyStimulus(6'h08, 1, 1, 0, 4'd11, "addi_wb");

    // sw completing normally after a one-cycle write stall.
    applyStimulus(6'h2B, 1, 1, 0, 4'd0, "sw_fetch");
    applyStimulus(6'h2B, 1, 1, 0, 4'd1, "sw_decode");
    applyStimulus(6'h2B, 1, 1, 0, 4'd2, "sw_memadr");
    applyStimulus(6'h2B, 1, 0, 0, 4'd5, "sw_memwr_wait");
    applyStimulus(6'h2B, 1, 1, 0, 4'd5, "sw_memwr_done");

    // lw with a stalled memory read.
    applyStimulus(6'h23, 0, 1, 0, 4'd0, "lws_fetch");
    applyStimulus(6'h23, 0, 1, 0, 4'd1, "lws_decode");
    applyStimulus(6'h23, 0, 1, 0, 4'd2, "lws_memadr");
    applyStimulus(6'h23, 0, 0, 0, 4'd3, "lws_memrd_wait");
    applyStimulus(6'h23, 0, 1, 0, 4'd3, "lws_memrd_done");
    applyStimulus(6'h23, 0, 1, 0, 4'd4, "lws_memwb");

    // Reset while stuck in MEMWR with mem_write asserted.
    applyStimulus(6'h2B, 1, 1, 0, 4'd0, "rsw_fetch");
    applyStimulus(6'h2B, 1, 1, 0, 4'd1, "rsw_decode");
    applyStimulus(6'h2B, 1, 1, 0, 4'd2, "rsw_memadr");
    applyStimulus(6'h2B, 1, 0, 0, 4'd5, "rsw_memwr_wait");
    applyStimulus(6'h2B, 1, 1, 1, 4'd0, "rsw_reset_edge1");
    applyStimulus(6'h2B, 1, 1, 1, 4'd0, "rsw_reset_edge2");
    applyStimulus(6'h2B, 1, 0, 0, 4'd0, "rsw_after_fetch");
    applyStimulus(6'h2B, 1, 1, 0, 4'd0, "rsw_after_ready");
    applyStimulus(6'h2B, 1, 1, 0, 4'd1, "rsw_after_decode");

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
